// File: rtl/write_back_arbiter_pkg.sv
// write_back_arbiter_pkg
//   Shared types for the write-back path: the register-file write port
//   record, the result-source identifier and a generic result record.
//   No ports; imported by write_back_arbiter and wb_scoreboard.
package write_back_arbiter_pkg;

  // Register-file write port control, registered by the arbiter
  typedef struct packed {
    logic       write_enable;
    logic [4:0] addr_rd;
  } reg_file_write_params_t;

  // Which producer holds the write-port grant
  typedef enum logic [1:0] {
    WB_SRC_ALU,
    WB_SRC_MEM,
    WB_SRC_MDU
  } wb_source_t;

  // One result offered to (or selected by) the arbiter
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_result_t;

endpackage

// File: rtl/write_back_arbiter_scoreboard.sv
// wb_scoreboard
//   32-entry pending-write tracker for long-latency results (loads, MDU).
//   Ports:
//     clk, reset         core clock, async active-high reset
//     set_valid_i/rd_i   mark a destination as pending (rd 0 ignored)
//     clr_valid_i/rd_i   retire a pending destination
//     rs1_addr_i/rs2_i   decode source registers
//     busy_mask_o        current pending set, bit 0 always 0
//     hazard_o           a source register has a pending write
module wb_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_valid_i,
  input  logic [4:0]  set_rd_i,
  input  logic        clr_valid_i,
  input  logic [4:0]  clr_rd_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] busy_mask_o,
  output logic        hazard_o
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Clear is applied before set so that an issue landing in the same cycle
  // as a retirement of the same register leaves it pending (the new
  // instruction still owes a write). x0 is never tracked.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) begin
      busy_d[clr_rd_i] = 1'b0;
    end
    if (set_valid_i && (set_rd_i != 5'd0)) begin
      busy_d[set_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Pending-write register, dropped entirely on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard looks only at registered state, so a retirement on this edge
  // is visible in the same cycle the register file receives the value
  always_comb begin
    hazard_o = ((rs1_addr_i != 5'd0) && busy_q[rs1_addr_i]) ||
               ((rs2_addr_i != 5'd0) && busy_q[rs2_addr_i]);
  end

  assign busy_mask_o = busy_q;

endmodule

// File: rtl/write_back_arbiter.sv
// write_back_arbiter
//   Shares the single register-file write port between the ALU/PC path,
//   the load-return path and the multiply/divide unit. One grant per cycle,
//   registered write toward the register file, plus a RAW scoreboard.
//   Ports:
//     clk, reset                    core clock, async active-high reset
//     issue_valid/issue_rd          long-latency instruction dispatched
//     alu_*, mem_*, mdu_*           valid/ready result handshakes
//     reg_file_write_params, wb_data registered write toward the RF
//     rs1_addr, rs2_addr, hazard    decode RAW check
//     busy_mask                     scoreboard state
module write_back_arbiter
  import write_back_arbiter_pkg::*;
#(
  parameter int unsigned ALU_WAIT_MAX = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd,
  input  logic [31:0]            alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [4:0]             mem_rd,
  input  logic [31:0]            mem_data,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [4:0]             mdu_rd,
  input  logic [31:0]            mdu_data,
  output reg_file_write_params_t reg_file_write_params,
  output logic [31:0]            wb_data,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  output logic                   hazard,
  output logic [31:0]            busy_mask
);

  localparam logic [2:0] WaitMax = 3'(ALU_WAIT_MAX);
  localparam logic       LastMem = 1'b0;
  localparam logic       LastMdu = 1'b1;

  logic                   lastGrant_q, lastGrant_d;
  logic [2:0]             aluWait_q, aluWait_d;
  reg_file_write_params_t wbParams_q, wbParams_d;
  logic [31:0]            wbData_q, wbData_d;

  logic       aluStarved;
  logic       grantValid;
  wb_source_t grantSrc;
  wb_result_t winner;

  // Grant selection: a starved ALU beats everything, otherwise MEM/MDU
  // share round-robin and the ALU takes leftover cycles. A grant is only
  // ever given to a valid source, so ready doubles as the transfer strobe.
  always_comb begin
    grantValid = 1'b0;
    grantSrc   = WB_SRC_ALU;
    aluStarved = alu_valid && (aluWait_q >= WaitMax);
    if (!reset) begin
      if (aluStarved) begin
        grantValid = 1'b1;
        grantSrc   = WB_SRC_ALU;
      end else if (mem_valid && (!mdu_valid || (lastGrant_q == LastMdu))) begin
        grantValid = 1'b1;
        grantSrc   = WB_SRC_MEM;
      end else if (mdu_valid) begin
        grantValid = 1'b1;
        grantSrc   = WB_SRC_MDU;
      end else if (alu_valid) begin
        grantValid = 1'b1;
        grantSrc   = WB_SRC_ALU;
      end
    end
  end

  assign alu_ready = grantValid && (grantSrc == WB_SRC_ALU);
  assign mem_ready = grantValid && (grantSrc == WB_SRC_MEM);
  assign mdu_ready = grantValid && (grantSrc == WB_SRC_MDU);

  // Route the granted source's destination and value to the write register
  always_comb begin
    winner.valid = grantValid;
    case (grantSrc)
      WB_SRC_MEM: begin
        winner.rd   = mem_rd;
        winner.data = mem_data;
      end
      WB_SRC_MDU: begin
        winner.rd   = mdu_rd;
        winner.data = mdu_data;
      end
      default: begin
        winner.rd   = alu_rd;
        winner.data = alu_data;
      end
    endcase
  end

  // Fairness state: the pointer records the last MEM/MDU winner, and the
  // ALU wait count saturates so it cannot wrap back below the threshold
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (mem_ready) begin
      lastGrant_d = LastMem;
    end else if (mdu_ready) begin
      lastGrant_d = LastMdu;
    end
    aluWait_d = 3'd0;
    if (alu_valid && !alu_ready) begin
      aluWait_d = (aluWait_q == 3'd7) ? aluWait_q : (aluWait_q + 3'd1);
    end
  end

  // Next write toward the register file; x0 writes are consumed silently,
  // and idle cycles keep the last address/data on the bus
  always_comb begin
    wbParams_d.write_enable = winner.valid && (winner.rd != 5'd0);
    wbParams_d.addr_rd      = winner.valid ? winner.rd : wbParams_q.addr_rd;
    wbData_d                = winner.valid ? winner.data : wbData_q;
  end

  // Arbiter and output registers; reset starts with MEM preferred
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_q <= LastMdu;
      aluWait_q   <= 3'd0;
      wbParams_q  <= '0;
      wbData_q    <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      aluWait_q   <= aluWait_d;
      wbParams_q  <= wbParams_d;
      wbData_q    <= wbData_d;
    end
  end

  assign reg_file_write_params = wbParams_q;
  assign wb_data               = wbData_q;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_valid_i (issue_valid),
    .set_rd_i    (issue_rd),
    .clr_valid_i (mem_ready || mdu_ready),
    .clr_rd_i    (winner.rd),
    .rs1_addr_i  (rs1_addr),
    .rs2_addr_i  (rs2_addr),
    .busy_mask_o (busy_mask),
    .hazard_o    (hazard)
  );

endmodule

// File: tb/tb_write_back_arbiter.sv
// tb_write_back_arbiter
//   Scoreboard bench: each driven cycle predicts the grant and pushes the
//   expected register-file write; the write is popped and compared one
//   clock later. Busy mask and hazard are checked against a small model.
module tb_write_back_arbiter;
  import write_back_arbiter_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   issue_valid;
  logic [4:0]             issue_rd;
  logic                   alu_valid, alu_ready;
  logic [4:0]             alu_rd;
  logic [31:0]            alu_data;
  logic                   mem_valid, mem_ready;
  logic [4:0]             mem_rd;
  logic [31:0]            mem_data;
  logic                   mdu_valid, mdu_ready;
  logic [4:0]             mdu_rd;
  logic [31:0]            mdu_data;
  reg_file_write_params_t regFileWriteParams;
  logic [31:0]            wb_data;
  logic [4:0]             rs1_addr, rs2_addr;
  logic                   hazard;
  logic [31:0]            busy_mask;

  write_back_arbiter #(.ALU_WAIT_MAX(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .issue_valid           (issue_valid),
    .issue_rd              (issue_rd),
    .alu_valid             (alu_valid),
    .alu_ready             (alu_ready),
    .alu_rd                (alu_rd),
    .alu_data              (alu_data),
    .mem_valid             (mem_valid),
    .mem_ready             (mem_ready),
    .mem_rd                (mem_rd),
    .mem_data              (mem_data),
    .mdu_valid             (mdu_valid),
    .mdu_ready             (mdu_ready),
    .mdu_rd                (mdu_rd),
    .mdu_data              (mdu_data),
    .reg_file_write_params (regFileWriteParams),
    .wb_data               (wb_data),
    .rs1_addr              (rs1_addr),
    .rs2_addr              (rs2_addr),
    .hazard                (hazard),
    .busy_mask             (busy_mask)
  );

  // 10-unit clock, inputs change on the falling edge
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } expWrite_t;

  expWrite_t   expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] modelBusy;
  logic        modelLastMdu;
  int          modelAluWait;
  logic [4:0]  holdAddr;
  logic [31:0] holdData;
  logic        holdValid;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setIdle();
    issue_valid = 1'b0; issue_rd = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
  endtask

  task automatic modelReset();
    modelBusy    = 32'd0;
    modelLastMdu = 1'b1;
    modelAluWait = 0;
    holdAddr     = 5'd0;
    holdData     = 32'd0;
    holdValid    = 1'b1;
    expQ.delete();
  endtask

  function automatic logic expHazard(input logic [31:0] busy);
    return ((rs1_addr != 5'd0) && busy[rs1_addr]) || ((rs2_addr != 5'd0) && busy[rs2_addr]);
  endfunction

  // Called just after a falling edge with inputs already set: predicts and
  // checks the readies, queues the expected write, advances one clock and
  // compares what the DUT registered
  task automatic applyStimulus();
    int          expGrant;
    expWrite_t   e;
    logic [31:0] clrMask;
    logic [31:0] setMask;
    #1;
    if (alu_valid && modelAluWait >= 2)                expGrant = 1;
    else if (mem_valid && (!mdu_valid || modelLastMdu)) expGrant = 2;
    else if (mdu_valid)                                 expGrant = 3;
    else if (alu_valid)                                 expGrant = 1;
    else                                                expGrant = 0;
    checkOutput("alu_ready", 32'(alu_ready), 32'(expGrant == 1));
    checkOutput("mem_ready", 32'(mem_ready), 32'(expGrant == 2));
    checkOutput("mdu_ready", 32'(mdu_ready), 32'(expGrant == 3));
    clrMask = 32'd0;
    setMask = 32'd0;
    case (expGrant)
      1: begin
        e = '{we: (alu_rd != 5'd0), rd: alu_rd, data: alu_data};
        expQ.push_back(e);
      end
      2: begin
        e = '{we: (mem_rd != 5'd0), rd: mem_rd, data: mem_data};
        expQ.push_back(e);
        clrMask[mem_rd] = 1'b1;
        modelLastMdu = 1'b0;
      end
      3: begin
        e = '{we: (mdu_rd != 5'd0), rd: mdu_rd, data: mdu_data};
        expQ.push_back(e);
        clrMask[mdu_rd] = 1'b1;
        modelLastMdu = 1'b1;
      end
      default: ;
    endcase
    if (issue_valid && issue_rd != 5'd0) setMask[issue_rd] = 1'b1;
    modelBusy = ((modelBusy & ~clrMask) | setMask) & ~32'h1;
    if (alu_valid && expGrant != 1) modelAluWait = (modelAluWait == 7) ? 7 : modelAluWait + 1;
    else                            modelAluWait = 0;

    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("write_enable", 32'(regFileWriteParams.write_enable), 32'(e.we));
      if (e.we) begin
        checkOutput("addr_rd", 32'(regFileWriteParams.addr_rd), 32'(e.rd));
        checkOutput("wb_data", wb_data, e.data);
        holdAddr  = e.rd;
        holdData  = e.data;
        holdValid = 1'b1;
      end else begin
        holdValid = 1'b0;
      end
    end else begin
      checkOutput("write_enable_idle", 32'(regFileWriteParams.write_enable), 32'd0);
      if (holdValid) begin
        checkOutput("addr_rd_hold", 32'(regFileWriteParams.addr_rd), 32'(holdAddr));
        checkOutput("wb_data_hold", wb_data, holdData);
      end
    end
    checkOutput("busy_mask", busy_mask, modelBusy);
    checkOutput("hazard", 32'(hazard), 32'(expHazard(modelBusy)));
    @(negedge clk);
  endtask

  initial begin
    // Reset and idle: everything zero, no ready even with a valid present
    setIdle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_write_enable", 32'(regFileWriteParams.write_enable), 32'd0);
    checkOutput("rst_addr_rd", 32'(regFileWriteParams.addr_rd), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_busy_mask", busy_mask, 32'd0);
    checkOutput("rst_hazard", 32'(hazard), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h1234_5678;
    #1;
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_no_write", 32'(regFileWriteParams.write_enable), 32'd0);
    @(negedge clk);
    setIdle();
    reset = 1'b0;
    repeat (2) applyStimulus();

    // Single ALU result, then idle so the enable must drop again
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
    applyStimulus();
    setIdle();
    applyStimulus();

    // MEM and MDU both valid, ALU idle: strict alternation starting at MEM
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'hA000_0000 + 32'(i);
      mdu_valid = 1'b1; mdu_rd = 5'(20 + i); mdu_data = 32'hB000_0000 + 32'(i);
      applyStimulus();
    end

    // Add a waiting ALU: refused twice, granted on the third cycle
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hC000_0000 + 32'(i);
      mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hD000_0000 + 32'(i);
      alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hE000_0000 + 32'(i);
      applyStimulus();
    end
    setIdle();
    applyStimulus();

    // Scoreboard: issue rd 7, retire via MDU, then same-cycle set/clear on 9
    rs1_addr = 5'd7; rs2_addr = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd7;
    applyStimulus();
    setIdle();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_0777;
    applyStimulus();
    setIdle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0999;
    applyStimulus();
    setIdle();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0998;
    applyStimulus();

    // x0 handling: no scoreboard entry, transfer consumed without a write
    setIdle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    applyStimulus();
    setIdle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555_AAAA;
    applyStimulus();
    setIdle();
    applyStimulus();

    // Reset during the cycle a granted write is on the port
    issue_valid = 1'b1; issue_rd = 5'd12;
    applyStimulus();
    setIdle();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h0BAD_F00D;
    applyStimulus();
    reset = 1'b1;
    #1;
    checkOutput("midrst_write_enable", 32'(regFileWriteParams.write_enable), 32'd0);
    checkOutput("midrst_busy_mask", busy_mask, 32'd0);
    checkOutput("midrst_mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_still_low", 32'(regFileWriteParams.write_enable), 32'd0);
    @(negedge clk);
    setIdle();
    reset = 1'b0;
    modelReset();
    applyStimulus();

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 31));
      alu_valid   = 1'($urandom_range(0, 1));
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      mem_valid   = 1'($urandom_range(0, 1));
      mem_rd      = 5'($urandom_range(0, 31));
      mem_data    = $urandom;
      mdu_valid   = 1'($urandom_range(0, 1));
      mdu_rd      = 5'($urandom_range(0, 31));
      mdu_data    = $urandom;
      rs1_addr    = 5'($urandom_range(0, 31));
      rs2_addr    = 5'($urandom_range(0, 31));
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
